im_fetch_axi_master: RTL

Instruction-fetch AXI4 read master between the IF stage and the instruction-memory slave port. It converts a per-cycle fetch request (PC) into single-beat AXI read transactions. It returns the fetched word to the IF/ID pipeline register and drives the IF-side stall (`PCstall_axi`) while a fetch is outstanding. It also absorbs branch redirects by draining and discarding in-flight reads, because AXI cannot cancel a transaction.

---
 rtl/cpu_axi_pkg.sv | 17 +
 rtl/im_fetch_axi_master_if.sv | 40 ++++
 rtl/im_fetch_axi_master.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared AXI4 constants and FSM state types for the CPU's AXI masters.
// Used by both the instruction-fetch and data-side read masters.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } fetch_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

endpackage

// File: rtl/im_fetch_axi_master_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and a slave.
// Ports: master drives AR*, RREADY; slave drives ARREADY, R*.
interface im_fetch_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE,
    output ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE,
    input  ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/im_fetch_axi_master.sv
// Instruction-fetch AXI4 read master: one single-beat read per fetch,
// discarding in-flight reads on redirect.
// Ports: clk, rst (sync, active-high); req_i/addr_i fetch request;
// flush_i redirect; stall_o PC hold; inst_o/inst_valid_o/err_o result;
// bus: AXI AR/R master port.
module im_fetch_axi_master
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter logic [ID_W-1:0] AR_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              err_o,
  im_fetch_axi_master_if.master bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] inst_q;
  logic              kill_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              valid_q;
  logic              err_q;
  logic              bad_rsp;

  // RLAST is always set on a single-beat burst.
  logic unused_rlast;
  assign unused_rlast = bus.RLAST;

  assign bus.ARID    = AR_ID;
  assign bus.ARADDR  = addr_q;
  assign bus.ARLEN   = 8'd0;
  assign bus.ARSIZE  = AXI_SIZE_4B;
  assign bus.ARBURST = AXI_BURST_INCR;
  assign bus.ARVALID = arvalid_q;
  assign bus.RREADY  = rready_q;

  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign err_o        = err_q;

  assign bad_rsp = (bus.RRESP != AXI_RESP_OKAY)
                 || (bus.RID != AR_ID);

  // Only IDLE lets the request through
  // combinationally; DONE releases the PC.
  always_comb begin
    stall_o = 1'b1;
    unique case (state)
      IDLE:    stall_o = req_i;
      DONE:    stall_o = 1'b0;
      default: stall_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      inst_q    <= '0;
      kill_q    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            addr_q    <= addr_i;
            kill_q    <= 1'b0;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // AR cannot be withdrawn once
          // raised; remember the redirect.
          if (flush_i) kill_q <= 1'b1;
          if (bus.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (flush_i) kill_q <= 1'b1;
          if (bus.RVALID) begin
            rready_q <= 1'b0;
            if (kill_q || flush_i) begin
              state <= IDLE;
            end else begin
              state   <= DONE;
              valid_q <= 1'b1;
              if (bad_rsp) begin
                inst_q <= DATA_W'(INST_NOP);
                err_q  <= 1'b1;
              end else begin
                inst_q <= bus.RDATA;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
